// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: segment constants and FSM state type shared by the display encoder and capture logic
package seg_capture_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HELD
   } state_e;

endpackage

// File: rtl/seg_capture_seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of an active-low 7-segment pattern back to BCD
module seg7_to_bcd
   import seg_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       err
);

   // map each legal glyph to its digit; anything else is flagged
   always_comb begin
      bcd = BCD_INVALID;
      err = 1'b0;
      case (seg)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: reconstructs BCD digits from a multiplexed active-low 7-segment bus and publishes whole frames
module seg_capture
   import seg_capture_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_DIGITS-1:0]   an_in,
   input  logic [6:0]            seg_in,
   output logic [4*N_DIGITS-1:0] bcd_out,
   output logic [N_DIGITS-1:0]   digit_err,
   output logic                  frame_valid,
   output logic                  timeout
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [N_DIGITS-1:0]   r_an_s1, r_an_s2;
   logic [6:0]            r_seg_s1, r_seg_s2;
   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [IDX_W-1:0]      r_lat_idx, w_sel_idx;
   logic [6:0]            r_lat_seg;
   logic                  w_sel_valid, w_same, w_latch, w_accept;
   logic [3:0]            w_dec_bcd;
   logic                  w_dec_err;
   logic [4*N_DIGITS-1:0] r_shadow, r_bcd_out;
   logic [N_DIGITS-1:0]   r_shadow_err, r_digit_err, r_seen, w_acc_mask;
   logic                  w_seen_full, w_to_fire, r_frame_valid, r_timeout;
   logic [TO_W-1:0]       r_idle_cnt;

   // two-flop synchronizer; preset to all-ones so the bus reads as inactive out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an_s1  <= '1;
         r_an_s2  <= '1;
         r_seg_s1 <= '1;
         r_seg_s2 <= '1;
      end else begin
         r_an_s1  <= an_in;
         r_an_s2  <= r_an_s1;
         r_seg_s1 <= seg_in;
         r_seg_s2 <= r_seg_s1;
      end
   end

   // a selection is valid only when exactly one anode is driven low
   always_comb begin
      w_sel_idx   = '0;
      w_sel_valid = $onehot(~r_an_s2);
      for (int i = 0; i < N_DIGITS; i++)
         if (!r_an_s2[i]) w_sel_idx = IDX_W'(i);
   end

   assign w_same    = (w_sel_idx == r_lat_idx) && (r_seg_s2 == r_lat_seg);
   assign w_cnt_inc = r_cnt + 1'b1;

   // next-state logic: debounce {idx, seg} until it has been stable long enough
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_valid) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!w_sel_valid) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_same) begin
               w_latch   = 1'b1;
               w_cnt_nxt = CNT_W'(1);
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (!w_sel_valid || !w_same) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, stability counter and the latched candidate pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_lat_idx <= '0;
         r_lat_seg <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_lat_idx <= w_sel_idx;
            r_lat_seg <= r_seg_s2;
         end
      end
   end

   seg7_to_bcd u_dec (
      .seg (r_lat_seg),
      .bcd (w_dec_bcd),
      .err (w_dec_err)
   );

   assign w_acc_mask  = w_accept ? (N_DIGITS'(1) << r_lat_idx) : '0;
   assign w_seen_full = &r_seen;
   assign w_to_fire   = !w_seen_full && !w_accept && (r_seen != '0) &&
                        (r_idle_cnt == TO_W'(TIMEOUT_CYCLES));

   // shadow frame: an accepted digit overwrites its slot, even if already seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow     <= '0;
         r_shadow_err <= '0;
      end else if (w_accept) begin
         r_shadow[{r_lat_idx, 2'b00} +: 4] <= w_dec_bcd;
         r_shadow_err[r_lat_idx]           <= w_dec_err;
      end
   end

   // publish the shadow once every slot is seen; drop a stale partial frame after the idle timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen        <= '0;
         r_bcd_out     <= '0;
         r_digit_err   <= '0;
         r_frame_valid <= 1'b0;
         r_timeout     <= 1'b0;
         r_idle_cnt    <= '0;
      end else begin
         r_frame_valid <= w_seen_full;
         r_timeout     <= w_to_fire;
         r_idle_cnt    <= w_accept ? '0 :
                          (r_idle_cnt == TO_W'(TIMEOUT_CYCLES)) ? r_idle_cnt : r_idle_cnt + 1'b1;
         if (w_seen_full) begin
            r_bcd_out   <= r_shadow;
            r_digit_err <= r_shadow_err;
            r_seen      <= w_acc_mask;
         end else if (w_to_fire) begin
            r_seen <= '0;
         end else begin
            r_seen <= r_seen | w_acc_mask;
         end
      end
   end

   assign bcd_out     = r_bcd_out;
   assign digit_err   = r_digit_err;
   assign frame_valid = r_frame_valid;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: scenario bench for seg_capture with a frame scoreboard
module tb_seg_capture;

   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P1 = 7'b1111001;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] P3 = 7'b0110000;
   localparam logic [6:0] P4 = 7'b0011001;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P6 = 7'b0000010;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P8 = 7'b0000000;
   localparam logic [6:0] P9 = 7'b0010000;
   localparam logic [6:0] PA = 7'b0001000;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  err;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  an_in = 4'b1111;
   logic [6:0]  seg_in = 7'b1111111;
   logic [15:0] bcd_out;
   logic [3:0]  digit_err;
   logic        frame_valid;
   logic        timeout;

   int     errors = 0;
   int     checks = 0;
   int     n_frames = 0;
   int     n_timeouts = 0;
   int     cyc = 0;
   int     fv_cyc = -1;
   frame_t exp_q[$];
   frame_t exp_f;

   seg_capture #(
      .N_DIGITS       (4),
      .STABLE_CYCLES  (16),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .an_in       (an_in),
      .seg_in      (seg_in),
      .bcd_out     (bcd_out),
      .digit_err   (digit_err),
      .frame_valid (frame_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (timeout) n_timeouts++;
      if (frame_valid) begin
         n_frames++;
         fv_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got frame_valid with bcd_out=%h, required no frame", bcd_out);
         end else begin
            exp_f = exp_q.pop_front();
            checks++;
            if (bcd_out !== exp_f.bcd) begin
               errors++;
               $display("FAIL frame_bcd: got %h, required %h", bcd_out, exp_f.bcd);
            end
            checks++;
            if (digit_err !== exp_f.err) begin
               errors++;
               $display("FAIL frame_err: got %b, required %b", digit_err, exp_f.err);
            end
         end
      end
   end

   task automatic drive(input int idx, input logic [6:0] seg, input int n);
      an_in  = ~(4'b0001 << idx);
      seg_in = seg;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input logic [3:0] an, input int n);
      an_in  = an;
      seg_in = 7'b1111111;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scan(input logic [6:0] s0, s1, s2, s3);
      drive(0, s0, 40);
      drive(1, s1, 40);
      drive(2, s2, 40);
      drive(3, s3, 40);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h, required 0000", bcd_out); end
      checks++;
      if (digit_err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b, required 0000", digit_err); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b, required 0", frame_valid); end
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b, required 0", timeout); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int f0 = n_frames;
      int t0 = n_timeouts;
      exp_q.push_back({16'h4321, 4'b0000});
      scan(P1, P2, P3, P4);
      checks++;
      if (n_frames !== f0 + 1) begin errors++; $display("FAIL basic_count: got %0d frames, required %0d", n_frames - f0, 1); end
      checks++;
      if (n_timeouts !== t0) begin errors++; $display("FAIL basic_timeout: got %0d pulses, required 0", n_timeouts - t0); end
   endtask

   task automatic test_bad_digit();
      int f0 = n_frames;
      exp_q.push_back({16'h4F21, 4'b0100});
      scan(P1, P2, PA, P4);
      checks++;
      if (n_frames !== f0 + 1) begin errors++; $display("FAIL bad_digit_count: got %0d frames, required 1", n_frames - f0); end
   endtask

   task automatic test_glitch();
      int f0 = n_frames;
      logic [6:0] pats [4] = '{P1, P2, P3, P4};
      logic [6:0] prev = P4;
      exp_q.push_back({16'h4321, 4'b0000});
      for (int i = 0; i < 4; i++) begin
         drive(i, prev, 10);
         drive(i, pats[i], 40);
         prev = pats[i];
      end
      checks++;
      if (n_frames !== f0 + 1) begin errors++; $display("FAIL glitch_count: got %0d frames, required 1", n_frames - f0); end
   endtask

   task automatic test_two_low();
      int f0 = n_frames;
      int t0 = n_timeouts;
      an_in  = 4'b1100;
      seg_in = P8;
      repeat (100) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (n_frames !== f0) begin errors++; $display("FAIL two_low_frame: got %0d frames, required 0", n_frames - f0); end
      checks++;
      if (n_timeouts !== t0) begin errors++; $display("FAIL two_low_accept: got %0d timeouts, required 0", n_timeouts - t0); end
   endtask

   task automatic test_latency();
      int c0;
      exp_q.push_back({16'h8765, 4'b0000});
      drive(0, P5, 40);
      drive(1, P6, 40);
      drive(2, P7, 40);
      idle(4'b1111, 5);
      fv_cyc = -1;
      c0 = cyc;
      drive(3, P8, 40);
      checks++;
      if (fv_cyc - c0 !== 19) begin errors++; $display("FAIL latency: got %0d cycles, required 19", fv_cyc - c0); end
   endtask

   task automatic test_timeout();
      int f0 = n_frames;
      int t0 = n_timeouts;
      drive(0, P5, 40);
      drive(1, P6, 40);
      idle(4'b1111, 100);
      checks++;
      if (n_timeouts !== t0 + 1) begin errors++; $display("FAIL timeout_pulses: got %0d, required 1", n_timeouts - t0); end
      checks++;
      if (n_frames !== f0) begin errors++; $display("FAIL timeout_frame: got %0d frames, required 0", n_frames - f0); end
      checks++;
      if (bcd_out !== 16'h8765) begin errors++; $display("FAIL timeout_bcd: got %h, required 8765", bcd_out); end
      checks++;
      if (digit_err !== 4'b0000) begin errors++; $display("FAIL timeout_err: got %b, required 0000", digit_err); end
      exp_q.push_back({16'h0987, 4'b0000});
      scan(P7, P8, P9, P0);
      checks++;
      if (n_frames !== f0 + 1) begin errors++; $display("FAIL timeout_next_frame: got %0d frames, required 1", n_frames - f0); end
      checks++;
      if (n_timeouts !== t0 + 1) begin errors++; $display("FAIL timeout_repeat: got %0d pulses, required 1", n_timeouts - t0); end
   endtask

   task automatic test_reset_mid();
      int f0;
      drive(3, P9, 40);
      drive(2, P8, 40);
      drive(1, P7, 40);
      an_in  = 4'b1111;
      seg_in = 7'b1111111;
      rst_n  = 1'b0;
      #2;
      checks++;
      if (bcd_out !== 16'h0) begin errors++; $display("FAIL mid_reset_bcd: got %h, required 0000", bcd_out); end
      checks++;
      if (digit_err !== 4'h0) begin errors++; $display("FAIL mid_reset_err: got %b, required 0000", digit_err); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_fv: got %b, required 0", frame_valid); end
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL mid_reset_to: got %b, required 0", timeout); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      f0 = n_frames;
      exp_q.push_back({16'h9876, 4'b0000});
      drive(3, P9, 40);
      drive(2, P8, 40);
      drive(1, P7, 40);
      drive(0, P6, 40);
      checks++;
      if (n_frames !== f0 + 1) begin errors++; $display("FAIL mid_reset_count: got %0d frames, required 1", n_frames - f0); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_bad_digit();
      test_glitch();
      test_two_low();
      test_latency();
      test_timeout();
      test_reset_mid();
      idle(4'b1111, 10);
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL missing_frames: got %0d outstanding, required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
